// File: rtl/swc_ll_chain_walker_if.sv
// Walker-facing bundle: start/abort control, page stream, and linked-list read channel.
// slave = the walker itself; master = the port logic and linked list around it.
interface swc_ll_chain_walker_if #(
  parameter int g_page_addr_bits = 10
) ();
  logic                        start_i;
  logic [g_page_addr_bits-1:0] start_page_i;
  logic                        abort_i;
  logic                        busy_o;
  logic                        done_o;
  logic                        err_o;
  logic [g_page_addr_bits-1:0] page_o;
  logic                        page_valid_o;
  logic                        page_ready_i;
  logic                        ll_read_o;
  logic [g_page_addr_bits-1:0] ll_addr_o;
  logic                        ll_done_i;
  logic [g_page_addr_bits-1:0] ll_data_i;

  modport slave (
    input  start_i, start_page_i, abort_i, page_ready_i, ll_done_i, ll_data_i,
    output busy_o, done_o, err_o, page_o, page_valid_o, ll_read_o, ll_addr_o
  );

  modport master (
    output start_i, start_page_i, abort_i, page_ready_i, ll_done_i, ll_data_i,
    input  busy_o, done_o, err_o, page_o, page_valid_o, ll_read_o, ll_addr_o
  );
endinterface

// File: rtl/swc_ll_chain_walker.sv
// Walks a page chain: emits each page on a valid/ready stream while fetching its link in parallel.
// start -> first page valid in 1 cycle; the next page waits for both the downstream accept and the link.
module swc_ll_chain_walker #(
  parameter int                          g_page_addr_bits = 10,
  parameter int                          g_max_pages      = 64,
  parameter logic [g_page_addr_bits-1:0] g_eol_page       = {g_page_addr_bits{1'b1}}
) (
  input logic                 clk_i,
  input logic                 rst_i,
  swc_ll_chain_walker_if.slave bus
);
  localparam int             CW   = $clog2(g_max_pages + 1);
  localparam logic [CW-1:0]  MAXC = CW'(g_max_pages);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DRAIN} state_t;

  state_t                      state;
  logic [CW-1:0]               cnt;
  logic [g_page_addr_bits-1:0] nxt;
  logic                        emitted;
  logic                        fetched;

  logic                        accept;
  logic                        fetch;
  logic                        em_nx;
  logic                        fe_nx;
  logic [CW-1:0]               cnt_nx;
  logic [g_page_addr_bits-1:0] nxt_nx;

  assign accept = bus.page_valid_o & bus.page_ready_i;
  assign fetch  = bus.ll_read_o & bus.ll_done_i;
  assign em_nx  = emitted | accept;
  assign fe_nx  = fetched | fetch;
  assign cnt_nx = (accept && cnt != MAXC) ? cnt + 1'b1 : cnt;
  assign nxt_nx = fetch ? bus.ll_data_i : nxt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= S_IDLE;
      cnt              <= '0;
      nxt              <= '0;
      emitted          <= 1'b0;
      fetched          <= 1'b0;
      bus.busy_o       <= 1'b0;
      bus.done_o       <= 1'b0;
      bus.err_o        <= 1'b0;
      bus.page_o       <= '0;
      bus.page_valid_o <= 1'b0;
      bus.ll_read_o    <= 1'b0;
      bus.ll_addr_o    <= '0;
    end else begin
      bus.done_o <= 1'b0;
      bus.err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            if (bus.start_page_i == g_eol_page) begin
              bus.done_o <= 1'b1;
            end else begin
              state            <= S_WALK;
              cnt              <= '0;
              emitted          <= 1'b0;
              fetched          <= 1'b0;
              bus.busy_o       <= 1'b1;
              bus.page_o       <= bus.start_page_i;
              bus.page_valid_o <= 1'b1;
              bus.ll_addr_o    <= bus.start_page_i;
              bus.ll_read_o    <= 1'b1;
            end
          end
        end
        S_WALK: begin
          if (bus.abort_i) begin
            bus.page_valid_o <= 1'b0;
            // A read completing on the abort edge needs no drain.
            if (bus.ll_read_o && !bus.ll_done_i) begin
              state <= S_DRAIN;
            end else begin
              state         <= S_IDLE;
              bus.busy_o    <= 1'b0;
              bus.ll_read_o <= 1'b0;
            end
          end else begin
            if (accept) begin
              bus.page_valid_o <= 1'b0;
              emitted          <= 1'b1;
              cnt              <= cnt_nx;
            end
            if (fetch) begin
              bus.ll_read_o <= 1'b0;
              nxt           <= bus.ll_data_i;
              fetched       <= 1'b1;
            end
            if (em_nx && fe_nx) begin
              if (nxt_nx == g_eol_page) begin
                bus.done_o <= 1'b1;
                bus.busy_o <= 1'b0;
                state      <= S_IDLE;
              end else if (cnt_nx == MAXC) begin
                bus.err_o  <= 1'b1;
                bus.busy_o <= 1'b0;
                state      <= S_IDLE;
              end else begin
                bus.page_o       <= nxt_nx;
                bus.page_valid_o <= 1'b1;
                bus.ll_addr_o    <= nxt_nx;
                bus.ll_read_o    <= 1'b1;
                emitted          <= 1'b0;
                fetched          <= 1'b0;
              end
            end
          end
        end
        S_DRAIN: begin
          if (bus.ll_done_i) begin
            bus.ll_read_o <= 1'b0;
            bus.busy_o    <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/swc_ll_chain_walker.md
Name: swc_ll_chain_walker

Overview:
- Per-port client of the multiport page linked list.
- Given a start page, walks the page chain by issuing read requests through one linked-list read channel (level request/done strobe).
- Emits each page address downstream over a valid/ready stream until the end-of-chain marker is returned.
- Instantiated once per output port in front of the read pump and the packet-free logic.

Parameters:
- g_page_addr_bits, 10, width of page addresses and link data.
- g_max_pages, 64, chain length limit; exceeding it flags a broken/looped chain.
- g_eol_page, 2**g_page_addr_bits-1 (1023), link value marking end of chain.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  one-cycle strobe, begin walk; ignored unless idle
- start_page_i  in  g_page_addr_bits  first page of chain, sampled with start_i
- abort_i  in  1  one-cycle strobe, terminate walk early
- busy_o  out  1  high from accepted start until return to IDLE
- done_o  out  1  one-cycle pulse, chain ended normally (EOL reached)
- err_o  out  1  one-cycle pulse, g_max_pages emitted without EOL
- page_o  out  g_page_addr_bits  current page address
- page_valid_o  out  1  page_o valid
- page_ready_i  in  1  downstream accepts page_o
- ll_read_o  out  1  linked-list read request, level, held until ll_done_i
- ll_addr_o  out  g_page_addr_bits  page whose link is read; stable while ll_read_o=1
- ll_done_i  in  1  one-cycle done strobe from linked list
- ll_data_i  in  g_page_addr_bits  next-page link, valid when ll_done_i=1

Behaviour:
- Reset (async, any state):
  - state=IDLE
  - busy_o, done_o, err_o, page_valid_o, ll_read_o = 0
  - page_o, ll_addr_o = 0
  - page counter = 0
- All outputs are registered.
- IDLE:
  - start_i with start_page_i==g_eol_page: done_o pulses next cycle; stay IDLE; busy_o stays 0.
  - Otherwise: cur=start_page_i, cnt=0, go to WALK. Next cycle: busy_o=1, page_valid_o=1, page_o=cur, ll_read_o=1, ll_addr_o=cur.
- WALK: emit and fetch run concurrently; two internal flags, emitted and fetched.
  - Emit: page accepted on the edge where page_valid_o&page_ready_i. Then page_valid_o=0, cnt+1, emitted=1.
  - Fetch: ll_read_o cleared on the edge where ll_done_i=1; ll_data_i captured into nxt; fetched=1.
    - ll_read_o must not drop before done.
    - ll_done_i while ll_read_o=0 is ignored.
  - When emitted&fetched (either order, or same edge), on that edge:
    - nxt==g_eol_page: done_o pulse, go to IDLE.
    - else cnt==g_max_pages: err_o pulse, go to IDLE.
    - else cur=nxt, clear flags; page_valid_o=1 and ll_read_o=1 for the new page on the next cycle.
  - Throughput: one page per max(ll latency, ready latency)+1 cycles. Latency start_i to page_valid_o = 1 cycle.
- Abort:
  - abort_i in WALK with ll_read_o=0: go to IDLE; page_valid_o=0; no done/err pulse.
  - abort_i with ll_read_o=1: go to DRAIN. page_valid_o=0 immediately; ll_read_o held until ll_done_i, data discarded, then IDLE.
  - busy_o stays 1 throughout DRAIN.
  - abort_i in IDLE is ignored.
  - abort_i and start_i together in IDLE: start wins.
- done_o/err_o: pulse on the cycle busy_o falls. The counter saturates at g_max_pages; no wrap.
- start_i while busy_o=1 is ignored; no queuing.

Test Plan:
- Chain 5->9->12->EOL, responder latency 2, ready tied 1 -> page_o 5,9,12 each accepted once; ll_addr_o 5,9,12; done_o pulse after the third fetch; busy_o low next cycle; err_o never.
- start_page_i=1023 -> no ll_read_o, no page_valid_o, done_o pulse one cycle after start_i.
- Chain 3->7->EOL, ready held low 10 cycles per page, responder latency 1 -> ll_read_o drops after one done; walker waits for ready; order 3,7; done_o once.
- Looped chain 4->4, g_max_pages=64 -> exactly 64 pages of value 4 emitted, then err_o pulse; no done_o.
- abort_i 1 cycle after start while ll_read_o=1, responder latency 5 -> page_valid_o low next cycle; ll_read_o held until done; then busy_o=0; no done_o/err_o; next start works.
- rst_i asserted mid-WALK with ll_read_o=1 -> all outputs 0 immediately (async), state IDLE; new chain walks correctly after release.
